mems_dac_ctrl: RTL and testbench

Sequencer that drives the 24-bit MEMS SPI master to update a dual-channel 16-bit DAC (X/Y mirror axes). After reset it issues a fixed two-frame DAC init sequence. It then accepts (x, y) samples over a valid/ready handshake and converts each into two SPI frames: write X to channel A, then write Y to channel B with simultaneous update of all channels. It sits between the scan-pattern generator and the SPI master, and owns the SPI master's start/data inputs exclusively.

---
 rtl/mems_dac_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mems_dac_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mems_dac_ctrl.sv
// Sequencer feeding the MEMS SPI master: two-frame DAC init, then X/Y sample frames.
// Optional build macro MEMS_DAC_CLAMP_EN saturates latched codes to [CLAMP_MIN, CLAMP_MAX].
//
// state       | meaning
// INIT_SEND   | start init frame init_idx once SPI master is idle
// INIT_WAIT   | wait for init frame completion
// READY       | accept an (x, y) sample
// X_SEND      | start channel A write once SPI master is idle
// X_WAIT      | wait for channel A frame completion
// Y_SEND      | start channel B write + update-all once SPI master is idle
// Y_WAIT      | wait for channel B frame completion
module mems_dac_ctrl #(
  parameter logic [23:0] INIT_WORD0 = 24'h280001,
  parameter logic [23:0] INIT_WORD1 = 24'h380001,
  parameter int unsigned TIMEOUT    = 4096,
  parameter logic [15:0] CLAMP_MIN  = 16'h0000,
  parameter logic [15:0] CLAMP_MAX  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [23:0] spi_data,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  output logic        init_done,
  output logic        fault,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_INIT_SEND,
    S_INIT_WAIT,
    S_READY,
    S_X_SEND,
    S_X_WAIT,
    S_Y_SEND,
    S_Y_WAIT
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        init_idx;
  logic [15:0] x_q, y_q;
  logic [15:0] tcnt;
  logic        in_wait;
  logic        timeout_hit;
  logic        start_c;
  logic        ready_c;
  logic [23:0] data_c;

`ifdef MEMS_DAC_CLAMP_EN
  // An inverted window collapses onto CLAMP_MAX.
  localparam logic [15:0] CLAMP_LO = (CLAMP_MIN > CLAMP_MAX) ? CLAMP_MAX : CLAMP_MIN;

  function automatic logic [15:0] clamp_code(input logic [15:0] v);
    if (v > CLAMP_MAX)     return CLAMP_MAX;
    else if (v < CLAMP_LO) return CLAMP_LO;
    else                   return v;
  endfunction
`else
  logic unused_clamp_cfg;
  assign unused_clamp_cfg = ^{CLAMP_MIN, CLAMP_MAX};

  function automatic logic [15:0] clamp_code(input logic [15:0] v);
    return v;
  endfunction
`endif

  assign in_wait = (state == S_INIT_WAIT) || (state == S_X_WAIT) || (state == S_Y_WAIT);
  // A completion arriving on the terminal cycle still counts as success.
  assign timeout_hit = in_wait && !spi_new_data && (tcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT_SEND;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    ready_c   = 1'b0;
    data_c    = 24'h0;
    case (state)
      S_INIT_SEND: begin
        data_c = init_idx ? INIT_WORD1 : INIT_WORD0;
        if (!spi_busy) begin
          start_c   = 1'b1;
          state_nxt = S_INIT_WAIT;
        end
      end
      S_INIT_WAIT: begin
        data_c = init_idx ? INIT_WORD1 : INIT_WORD0;
        if (spi_new_data) state_nxt = init_idx ? S_READY : S_INIT_SEND;
        else if (timeout_hit) state_nxt = S_INIT_SEND;
      end
      S_READY: begin
        ready_c = 1'b1;
        if (sample_valid) state_nxt = S_X_SEND;
      end
      S_X_SEND: begin
        data_c = {8'h00, x_q};
        if (!spi_busy) begin
          start_c   = 1'b1;
          state_nxt = S_X_WAIT;
        end
      end
      S_X_WAIT: begin
        data_c = {8'h00, x_q};
        if (spi_new_data) state_nxt = S_Y_SEND;
        else if (timeout_hit) state_nxt = S_INIT_SEND;
      end
      S_Y_SEND: begin
        data_c = {8'h11, y_q};
        if (!spi_busy) begin
          start_c   = 1'b1;
          state_nxt = S_Y_WAIT;
        end
      end
      S_Y_WAIT: begin
        data_c = {8'h11, y_q};
        if (spi_new_data) state_nxt = S_READY;
        else if (timeout_hit) state_nxt = S_INIT_SEND;
      end
      default: state_nxt = S_INIT_SEND;
    endcase
  end

  // Outputs hold their reset values for as long as rst is asserted.
  assign spi_start    = start_c & ~rst;
  assign sample_ready = ready_c & ~rst;
  assign spi_data     = rst ? 24'h0 : data_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      tcnt      <= '0;
      init_done <= 1'b0;
      fault     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (start_c)      tcnt <= '0;
      else if (in_wait) tcnt <= tcnt + 16'd1;

      if (state == S_READY && sample_valid) begin
        x_q <= clamp_code(sample_x);
        y_q <= clamp_code(sample_y);
      end

      if (timeout_hit) begin
        fault     <= 1'b1;
        init_done <= 1'b0;
        init_idx  <= 1'b0;
        x_q       <= '0;
        y_q       <= '0;
      end else if (spi_new_data) begin
        if (state == S_INIT_WAIT) begin
          if (init_idx) init_done <= 1'b1;
          else          init_idx  <= 1'b1;
        end
        if (state == S_Y_WAIT) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mems_dac_ctrl.sv
// Directed bench for mems_dac_ctrl with a behavioural SPI master model.
// Inputs change at negedge+1; the SPI model acts at negedge and samples the DUT at negedge+2.
module tb_mems_dac_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_x = '0;
  logic [15:0] sample_y = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [23:0] spi_data;
  logic        spi_start;
  logic        spi_busy = 1'b0;
  logic        spi_new_data = 1'b0;
  logic        init_done;
  logic        fault;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          cnt = 0;
  int          resp_delay = 50;
  bit          resp_en = 1'b1;
  bit          abort = 1'b0;
  bit          active = 1'b0;
  bit          start_prev = 1'b0;
  int          width_err = 0;
  int          stab_err = 0;
  int          frame_goal = 0;
  logic [23:0] cur_frame = '0;
  logic [23:0] frames[$];
  int          start_cyc[$];
  int          nd_cyc[$];

  mems_dac_ctrl #(
    .TIMEOUT  (64),
    .CLAMP_MIN(16'h0100),
    .CLAMP_MAX(16'hFF00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_x    (sample_x),
    .sample_y    (sample_y),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .spi_data    (spi_data),
    .spi_start   (spi_start),
    .spi_busy    (spi_busy),
    .spi_new_data(spi_new_data),
    .init_done   (init_done),
    .fault       (fault),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // SPI master model: busy from the cycle after start, new_data resp_delay cycles after start.
  always @(negedge clk) begin
    cyc++;
    spi_new_data = 1'b0;
    if (rst) begin
      active   = 1'b0;
      spi_busy = 1'b0;
    end else if (active) begin
      cnt++;
      if (resp_en && cnt >= resp_delay) begin
        spi_new_data = 1'b1;
        spi_busy     = 1'b0;
        active       = 1'b0;
        nd_cyc.push_back(cyc);
      end else begin
        spi_busy = 1'b1;
      end
    end
    #2;
    if (abort) begin
      abort    = 1'b0;
      active   = 1'b0;
      spi_busy = 1'b0;
      #1;
    end
    if (!rst) begin
      if (active && spi_data !== cur_frame) stab_err++;
      if (spi_start) begin
        if (start_prev) width_err++;
        frames.push_back(spi_data);
        start_cyc.push_back(cyc);
        cur_frame = spi_data;
        active    = 1'b1;
        cnt       = 0;
      end
      start_prev = spi_start;
    end else begin
      start_prev = 1'b0;
    end
  end

  function automatic logic [23:0] fr(input int i);
    return (i < frames.size()) ? frames[i] : 24'hxxxxxx;
  endfunction

  function automatic int sc(input int i);
    return (i < start_cyc.size()) ? start_cyc[i] : -1;
  endfunction

  function automatic int nc(input int i);
    return (i < nd_cyc.size()) ? nd_cyc[i] : -100;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    frames.delete();
    start_cyc.delete();
    nd_cyc.delete();
  endtask

  // sel: 0 init_done, 1 sample_ready, 2 fault, 3 frames.size() >= frame_goal
  task automatic wait_until(input int sel, input int lim, input string name);
    bit hit;
    for (int n = 0; n < lim; n++) begin
      case (sel)
        0:       hit = (init_done === 1'b1);
        1:       hit = (sample_ready === 1'b1);
        2:       hit = (fault === 1'b1);
        default: hit = (frames.size() >= frame_goal);
      endcase
      if (hit) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL %s timed out after %0d cycles", name, lim);
  endtask

  task automatic handshake(input logic [15:0] x, input logic [15:0] y, output int hs);
    sample_x     = x;
    sample_y     = y;
    sample_valid = 1'b1;
    wait_until(1, 400, "handshake_ready");
    hs = cyc;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", sample_ready); end
    checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", spi_start); end
    checks++; if (spi_data !== 24'h0) begin errors++; $display("FAIL rst_data got %h exp 000000", spi_data); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b exp 0", init_done); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", fault); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rst_frame_cnt got %h exp 0000", frame_cnt); end
  endtask

  task automatic test_init();
    int rel;
    clear_log();
    resp_delay = 50;
    rel = cyc;
    rst = 1'b0;
    wait_until(0, 400, "init_done_wait");
    checks++; if (frames.size() != 2) begin errors++; $display("FAIL init_nframes got %0d exp 2", frames.size()); end
    checks++; if (fr(0) !== 24'h280001) begin errors++; $display("FAIL init_frame0 got %h exp 280001", fr(0)); end
    checks++; if (fr(1) !== 24'h380001) begin errors++; $display("FAIL init_frame1 got %h exp 380001", fr(1)); end
    checks++; if (sc(0) != rel) begin errors++; $display("FAIL init_first_start got %0d exp %0d", sc(0), rel); end
    checks++; if (nc(0) != rel + 50) begin errors++; $display("FAIL init_nd0_cycle got %0d exp %0d", nc(0), rel + 50); end
    checks++; if (cyc != nc(1) + 1) begin errors++; $display("FAIL init_done_cycle got %0d exp %0d", cyc, nc(1) + 1); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL init_ready got %b exp 1", sample_ready); end
  endtask

  task automatic test_single();
    int hs;
    clear_log();
    handshake(16'h1234, 16'hABCD, hs);
    frame_goal = 2;
    wait_until(3, 400, "single_frames");
    wait_until(1, 400, "single_ready");
    checks++; if (fr(0) !== 24'h001234) begin errors++; $display("FAIL single_x_frame got %h exp 001234", fr(0)); end
    checks++; if (fr(1) !== 24'h11ABCD) begin errors++; $display("FAIL single_y_frame got %h exp 11abcd", fr(1)); end
    checks++; if (sc(0) != hs + 1) begin errors++; $display("FAIL single_x_start got %0d exp %0d", sc(0), hs + 1); end
    checks++; if (sc(1) != nc(0) + 1) begin errors++; $display("FAIL single_y_start got %0d exp %0d", sc(1), nc(0) + 1); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt got %0d exp 1", frame_cnt); end
    checks++; if (cyc != nc(1) + 1) begin errors++; $display("FAIL single_ready_cycle got %0d exp %0d", cyc, nc(1) + 1); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs[3];
    logic [15:0] ys[3];
    int          hs[3];
    xs = '{16'h0A0A, 16'h5555, 16'hC3C3};
    ys = '{16'h1111, 16'hAAAA, 16'hFF00};
    clear_log();
    resp_delay = 5;
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_x = xs[i];
      sample_y = ys[i];
      wait_until(1, 400, "b2b_ready");
      hs[i] = cyc;
      step();
    end
    sample_valid = 1'b0;
    frame_goal = 6;
    wait_until(3, 400, "b2b_frames");
    wait_until(1, 400, "b2b_final_ready");
    for (int k = 0; k < 3; k++) begin
      checks++; if (fr(2*k) !== {8'h00, xs[k]}) begin errors++; $display("FAIL b2b_x_frame%0d got %h exp %h", k, fr(2*k), {8'h00, xs[k]}); end
      checks++; if (fr(2*k+1) !== {8'h11, ys[k]}) begin errors++; $display("FAIL b2b_y_frame%0d got %h exp %h", k, fr(2*k+1), {8'h11, ys[k]}); end
      checks++; if (sc(2*k) != hs[k] + 1) begin errors++; $display("FAIL b2b_x_start%0d got %0d exp %0d", k, sc(2*k), hs[k] + 1); end
      checks++; if (sc(2*k+1) != nc(2*k) + 1) begin errors++; $display("FAIL b2b_y_start%0d got %0d exp %0d", k, sc(2*k+1), nc(2*k) + 1); end
    end
    for (int k = 1; k < 3; k++) begin
      checks++; if (hs[k] != nc(2*k-1) + 1) begin errors++; $display("FAIL b2b_accept%0d got %0d exp %0d", k, hs[k], nc(2*k-1) + 1); end
    end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL b2b_frame_cnt got %0d exp 4", frame_cnt); end
    checks++; if (width_err != 0) begin errors++; $display("FAIL b2b_start_width got %0d wide pulses exp 0", width_err); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL b2b_data_stable got %0d changes exp 0", stab_err); end
  endtask

  task automatic test_clamp();
    int          hs;
    logic [23:0] exp_x, exp_y;
`ifdef MEMS_DAC_CLAMP_EN
    exp_x = 24'h000100;
    exp_y = 24'h11FF00;
`else
    exp_x = 24'h000000;
    exp_y = 24'h11FFFF;
`endif
    clear_log();
    handshake(16'h0000, 16'hFFFF, hs);
    frame_goal = 2;
    wait_until(3, 400, "clamp_frames");
    wait_until(1, 400, "clamp_ready");
    checks++; if (fr(0) !== exp_x) begin errors++; $display("FAIL clamp_x_frame got %h exp %h", fr(0), exp_x); end
    checks++; if (fr(1) !== exp_y) begin errors++; $display("FAIL clamp_y_frame got %h exp %h", fr(1), exp_y); end
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL clamp_frame_cnt got %0d exp 5", frame_cnt); end
  endtask

  task automatic test_timeout();
    int hs;
    clear_log();
    resp_en = 1'b0;
    handshake(16'h0300, 16'h0400, hs);
    wait_until(2, 200, "timeout_fault");
    checks++; if (cyc != sc(0) + 65) begin errors++; $display("FAIL timeout_cycle got %0d exp %0d", cyc, sc(0) + 65); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL timeout_init_done got %b exp 0", init_done); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL timeout_ready got %b exp 0", sample_ready); end
    resp_en    = 1'b1;
    resp_delay = 5;
    abort      = 1'b1;
    wait_until(0, 400, "timeout_reinit");
    checks++; if (fr(0) !== 24'h000300) begin errors++; $display("FAIL timeout_x_frame got %h exp 000300", fr(0)); end
    checks++; if (fr(1) !== 24'h280001) begin errors++; $display("FAIL timeout_reinit0 got %h exp 280001", fr(1)); end
    checks++; if (fr(2) !== 24'h380001) begin errors++; $display("FAIL timeout_reinit1 got %h exp 380001", fr(2)); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_fault_sticky got %b exp 1", fault); end
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL timeout_frame_cnt got %0d exp 5", frame_cnt); end
  endtask

  task automatic test_rst_mid();
    int hs;
    int rel;
    clear_log();
    resp_delay = 50;
    handshake(16'h1111, 16'h2222, hs);
    frame_goal = 1;
    wait_until(3, 100, "rst_mid_xstart");
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", sample_ready); end
    checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rstmid_start got %b exp 0", spi_start); end
    checks++; if (spi_data !== 24'h0) begin errors++; $display("FAIL rstmid_data got %h exp 000000", spi_data); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rstmid_init_done got %b exp 0", init_done); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rstmid_fault got %b exp 0", fault); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_frame_cnt got %h exp 0000", frame_cnt); end
    clear_log();
    resp_delay = 5;
    rel = cyc;
    rst = 1'b0;
    wait_until(0, 400, "rstmid_reinit");
    checks++; if (fr(0) !== 24'h280001) begin errors++; $display("FAIL rstmid_reinit0 got %h exp 280001", fr(0)); end
    checks++; if (sc(0) != rel) begin errors++; $display("FAIL rstmid_first_start got %0d exp %0d", sc(0), rel); end
    checks++; if (fr(1) !== 24'h380001) begin errors++; $display("FAIL rstmid_reinit1 got %h exp 380001", fr(1)); end
    checks++; if (width_err != 0) begin errors++; $display("FAIL final_start_width got %0d exp 0", width_err); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL final_data_stable got %0d exp 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single();
    test_back_to_back();
    test_clamp();
    test_timeout();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
